// File: rtl/ahb_lite_arbiter_2m.sv
// ahb_lite_arbiter_2m: two-master AHB-Lite arbiter, grant handover only at hready boundaries outside bursts
// Ports: hclk/hresetn (async active-low); hbusreq_mN in / hgrant_mN out per master;
//   haddr/htrans/hwrite/hsize/hburst/hwdata_mN master buses in; haddr/htrans/hwrite/hsize/hburst/hwdata slave bus out;
//   hready/hresp/hrdata from slave, broadcast unchanged as hready_m/hresp_m/hrdata_m; amaster = address-phase owner.
// Define AHB_ARB_RR_EN for round-robin on contention; undefined gives fixed priority to M0.
module ahb_lite_arbiter_2m #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hbusreq_m0,
  input  logic              hbusreq_m1,
  output logic              hgrant_m0,
  output logic              hgrant_m1,
  input  logic [ADDR_W-1:0] haddr_m0,
  input  logic [ADDR_W-1:0] haddr_m1,
  input  logic [1:0]        htrans_m0,
  input  logic [1:0]        htrans_m1,
  input  logic              hwrite_m0,
  input  logic              hwrite_m1,
  input  logic [2:0]        hsize_m0,
  input  logic [2:0]        hsize_m1,
  input  logic [2:0]        hburst_m0,
  input  logic [2:0]        hburst_m1,
  input  logic [DATA_W-1:0] hwdata_m0,
  input  logic [DATA_W-1:0] hwdata_m1,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [1:0]        hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic              hready_m,
  output logic [1:0]        hresp_m,
  output logic [DATA_W-1:0] hrdata_m,
  output logic              amaster
);
  logic       r_gnt, r_amaster, r_dmaster;
  logic       w_arb, w_pick, w_gnt_nxt;
  logic [1:0] w_trans_a;
  logic [2:0] w_burst_a;
  // Re-arbitrate only when the address-phase owner is idle or issuing a single beat,
  // so a burst in flight always keeps the bus.
  always_comb begin
    w_trans_a = r_amaster ? htrans_m1 : htrans_m0;
    w_burst_a = r_amaster ? hburst_m1 : hburst_m0;
    w_arb     = hready && (w_trans_a == 2'b00 || (w_trans_a == 2'b10 && w_burst_a == 3'b000));
    w_gnt_nxt = !w_arb ? r_gnt :
                (hbusreq_m0 && hbusreq_m1) ? w_pick :
                hbusreq_m0 ? 1'b0 :
                hbusreq_m1 ? 1'b1 : r_gnt;
  end
`ifdef AHB_ARB_RR_EN
  logic r_last;
  assign w_pick = ~r_last;
  // Track every decision driven by a request, even when gnt does not move,
  // so continuous contention still alternates.
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) r_last <= 1'b1;
    else if (w_arb && (hbusreq_m0 || hbusreq_m1)) r_last <= w_gnt_nxt;
`else
  assign w_pick = 1'b0;
`endif
  // Wait states freeze grant and both phase owners.
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      r_gnt     <= 1'b0;
      r_amaster <= 1'b0;
      r_dmaster <= 1'b0;
    end else if (hready) begin
      r_gnt     <= w_gnt_nxt;
      r_amaster <= r_gnt;
      r_dmaster <= r_amaster;
    end
  assign hgrant_m0 = ~r_gnt;
  assign hgrant_m1 = r_gnt;
  assign amaster   = r_amaster;
  assign haddr     = r_amaster ? haddr_m1  : haddr_m0;
  assign htrans    = r_amaster ? htrans_m1 : htrans_m0;
  assign hwrite    = r_amaster ? hwrite_m1 : hwrite_m0;
  assign hsize     = r_amaster ? hsize_m1  : hsize_m0;
  assign hburst    = r_amaster ? hburst_m1 : hburst_m0;
  assign hwdata    = r_dmaster ? hwdata_m1 : hwdata_m0;
  assign hready_m  = hready;
  assign hresp_m   = hresp;
  assign hrdata_m  = hrdata;
endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// tb_ahb_lite_arbiter_2m: scoreboard bench for the two-master AHB-Lite arbiter
module tb_ahb_lite_arbiter_2m;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  logic        hclk = 1'b0, hresetn = 1'b0;
  logic        hbusreq_m0, hbusreq_m1, hgrant_m0, hgrant_m1;
  logic [31:0] haddr_m0, haddr_m1, hwdata_m0, hwdata_m1, haddr, hwdata, hrdata, hrdata_m;
  logic [1:0]  htrans_m0, htrans_m1, htrans, hresp, hresp_m;
  logic        hwrite_m0, hwrite_m1, hwrite, hready, hready_m, amaster;
  logic [2:0]  hsize_m0, hsize_m1, hsize, hburst_m0, hburst_m1, hburst;
  ahb_lite_arbiter_2m dut (
    .hclk(hclk), .hresetn(hresetn),
    .hbusreq_m0(hbusreq_m0), .hbusreq_m1(hbusreq_m1),
    .hgrant_m0(hgrant_m0), .hgrant_m1(hgrant_m1),
    .haddr_m0(haddr_m0), .haddr_m1(haddr_m1),
    .htrans_m0(htrans_m0), .htrans_m1(htrans_m1),
    .hwrite_m0(hwrite_m0), .hwrite_m1(hwrite_m1),
    .hsize_m0(hsize_m0), .hsize_m1(hsize_m1),
    .hburst_m0(hburst_m0), .hburst_m1(hburst_m1),
    .hwdata_m0(hwdata_m0), .hwdata_m1(hwdata_m1),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .hready_m(hready_m), .hresp_m(hresp_m), .hrdata_m(hrdata_m),
    .amaster(amaster)
  );
  always #5 hclk = ~hclk;
  typedef struct packed {logic g; logic a; logic d;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic compare(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, "_gnt"}, 64'({hgrant_m1, hgrant_m0}), 64'({e.g, ~e.g}));
    check({tag, "_amaster"}, 64'(amaster), 64'(e.a));
    check({tag, "_haddr"}, 64'(haddr), 64'(e.a ? haddr_m1 : haddr_m0));
    check({tag, "_ctl"}, 64'({htrans, hburst, hwrite, hsize}),
          64'(e.a ? {htrans_m1, hburst_m1, hwrite_m1, hsize_m1} : {htrans_m0, hburst_m0, hwrite_m0, hsize_m0}));
    check({tag, "_hwdata"}, 64'(hwdata), 64'(e.d ? hwdata_m1 : hwdata_m0));
  endtask
  task automatic step(input string tag, input logic g, input logic a, input logic d);
    sb.push_back({g, a, d});
    @(posedge hclk);
    #1;
    compare(tag);
  endtask
  initial begin
    logic g, pg, pa;
    hbusreq_m0 = 0; hbusreq_m1 = 0;
    htrans_m0 = IDLE; htrans_m1 = IDLE;
    hburst_m0 = 3'b000; hburst_m1 = 3'b000;
    hwrite_m0 = 0; hwrite_m1 = 1;
    hsize_m0 = 3'b010; hsize_m1 = 3'b001;
    haddr_m0 = 32'h1000_0000; haddr_m1 = 32'h2000_0010;
    hwdata_m0 = 32'h0000_C0DE; hwdata_m1 = 32'hA5A5_5A5A;
    hready = 1; hresp = 2'b00; hrdata = 32'h1234_5678;
    #1;
    sb.push_back(3'b000);
    compare("reset");
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1;
    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0);
    hresp = 2'b01; hrdata = 32'hDEAD_BEEF; hready = 0;
    #1;
    check("passthru", 64'({hready_m, hresp_m, hrdata_m}), 64'({1'b0, 2'b01, 32'hDEAD_BEEF}));
    hready = 1; hresp = 2'b00;
    hbusreq_m1 = 1;
    step("m1_req", 1, 0, 0);
    step("m1_gnt", 1, 1, 0);
    htrans_m1 = NONSEQ;
    #1;
    check("m1_addr", 64'(haddr), 64'(32'h2000_0010));
    step("m1_nseq", 1, 1, 1);
    check("m1_wdata", 64'(hwdata), 64'(32'hA5A5_5A5A));
    htrans_m1 = IDLE; hbusreq_m1 = 0;
    step("m1_park", 1, 1, 1);
    hbusreq_m0 = 1;
    step("m0_req", 0, 1, 1);
    step("m0_gnt", 0, 0, 1);
    step("m0_own", 0, 0, 0);
    htrans_m0 = NONSEQ; hburst_m0 = 3'b011; hwrite_m0 = 1;
    step("beat1", 0, 0, 0);
    htrans_m0 = SEQ; hbusreq_m0 = 0; hbusreq_m1 = 1;
    for (int i = 2; i <= 4; i++) step("beat_seq", 0, 0, 0);
    htrans_m0 = IDLE; hburst_m0 = 3'b000;
    step("burst_end", 1, 0, 0);
    step("burst_hand", 1, 1, 0);
    hbusreq_m1 = 0;
    step("burst_m1", 1, 1, 1);
    hbusreq_m0 = 1;
    step("ws_req", 0, 1, 1);
    step("ws_gnt", 0, 0, 1);
    htrans_m0 = NONSEQ; hbusreq_m0 = 0; hbusreq_m1 = 1;
    step("ws_addr", 1, 0, 0);
    htrans_m0 = IDLE; hready = 0;
    for (int i = 0; i < 3; i++) step("ws_wait", 1, 0, 0);
    hready = 1;
    step("ws_accept", 1, 1, 0);
    htrans_m1 = NONSEQ;
    step("ws_m1", 1, 1, 1);
    htrans_m1 = IDLE; hbusreq_m1 = 0;
    hbusreq_m0 = 1; hbusreq_m1 = 1;
    pg = 1; pa = 1;
    for (int i = 1; i <= 8; i++) begin
      htrans_m0 = pa ? IDLE : NONSEQ;
      htrans_m1 = pa ? NONSEQ : IDLE;
`ifdef AHB_ARB_RR_EN
      g = (i % 2 == 0);
`else
      g = 1'b0;
`endif
      step("contend", g, pg, pa);
      pa = pg;
      pg = g;
    end
    htrans_m0 = IDLE; htrans_m1 = IDLE; hbusreq_m0 = 0; hbusreq_m1 = 0;
    hresetn = 0;
    #1;
    sb.push_back(3'b000);
    compare("rst_pulse");
    @(negedge hclk);
    hresetn = 1;
    hbusreq_m1 = 1;
    step("r_req", 1, 0, 0);
    step("r_gnt", 1, 1, 0);
    htrans_m1 = NONSEQ; hburst_m1 = 3'b011;
    step("r_beat1", 1, 1, 1);
    htrans_m1 = SEQ;
    step("r_beat2", 1, 1, 1);
    #2 hresetn = 0;
    #1;
    sb.push_back(3'b000);
    compare("rst_mid");
    htrans_m1 = IDLE; hburst_m1 = 3'b000; hbusreq_m1 = 0;
    @(negedge hclk);
    hresetn = 1;
    step("post_rst", 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
